// File: rtl/mvm_input_feeder.sv
// ----------------------------------------------------------------------------
// mvm_input_feeder
//
// Upstream stage of the matrix-vector multiplier. Collects one job (matrix A
// row-major, then vector x; TOTAL = N*(N+1) words) from a valid/ready word
// stream into a local buffer. It then issues a one-cycle start pulse to the
// multiplier and replays the job on the multiplier's serial data input in
// TOTAL consecutive cycles. The next job is withheld until the multiplier has
// signalled done and POST_DONE_GAP cycles have elapsed.
//
// Build option:
//   MVM_FEEDER_DBLBUF_EN  defined   -> two buffer banks (ping/pong). A new job
//                                      is loaded into the free bank while the
//                                      other bank streams or waits for done.
//                         undefined -> single bank; no input is accepted from
//                                      the cycle after the last word until the
//                                      post-done gap has completed.
//
// Ports:
//   clk        in   1            clock, all state on rising edge
//   reset      in   1            synchronous, active-high
//   in_valid   in   1            upstream word valid
//   in_ready   out  1            feeder accepts word (registered)
//   in_data    in   INPUT_WIDTH  upstream word (signed, passed through as-is)
//   mvm_start  out  1            one-cycle start pulse (registered)
//   mvm_data   out  INPUT_WIDTH  word to multiplier data_in (registered)
//   mvm_done   in   1            multiplier done pulse
//   busy       out  1            a job is held, streaming, or awaiting done/gap
// ----------------------------------------------------------------------------
module mvm_input_feeder #(
    parameter int MAT_SCALE     = 4,
    parameter int INPUT_WIDTH   = 8,
    parameter int POST_DONE_GAP = MAT_SCALE + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_data,
    output logic                   mvm_start,
    output logic [INPUT_WIDTH-1:0] mvm_data,
    input  logic                   mvm_done,
    output logic                   busy
);

    localparam int TOTAL = MAT_SCALE * (MAT_SCALE + 1);
`ifdef MVM_FEEDER_DBLBUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int CW = $clog2(TOTAL + 1);
    localparam int AW = $clog2(NBANK * TOTAL);
    localparam int GW = $clog2(POST_DONE_GAP + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
    // The mvm_done cycle itself counts as the first idle cycle, so GAP
    // occupies POST_DONE_GAP-1 cycles and LOAD resumes POST_DONE_GAP cycles
    // after the done pulse.
    localparam logic [GW-1:0] GAP_LAST = GW'(POST_DONE_GAP - 2);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [CW-1:0]          r_wr_cnt;
    logic [CW-1:0]          r_rd_cnt;
    logic [GW-1:0]          r_gap_cnt;
    logic                   r_wr_bank;
    logic                   r_rd_bank;
    logic [1:0]             r_full;
    logic                   r_in_ready;
    logic                   r_mvm_start;
    logic [INPUT_WIDTH-1:0] r_mvm_data;
    logic [INPUT_WIDTH-1:0] r_buf [NBANK*TOTAL];

    // ------------------------------------------------------------------
    // Next-state / combinational signals
    // ------------------------------------------------------------------
    state_t                 w_state_next;
    logic [CW-1:0]          w_rd_cnt_next;
    logic [GW-1:0]          w_gap_cnt_next;
    logic                   w_rd_bank_next;
    logic                   w_wr_bank_next;
    logic                   w_release;
    logic [INPUT_WIDTH-1:0] w_mvm_data_next;
    logic                   w_xfer;
    logic                   w_fill_done;
    logic [1:0]             w_full_next;
    logic [CW-1:0]          w_rd_idx;
    logic [AW-1:0]          w_raddr;
    logic [AW-1:0]          w_waddr;
    logic [INPUT_WIDTH-1:0] w_rdata;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_fill_done = w_xfer && (r_wr_cnt == LAST_IDX);

    assign w_waddr = AW'(r_wr_cnt) + (r_wr_bank ? AW'(TOTAL) : AW'(0));

    // Word prefetched into the mvm_data register: word 0 while in START,
    // word rd_cnt+1 while streaming (rd_cnt tracks the word on mvm_data).
    always_comb begin
        w_rd_idx = '0;
        if (r_state == ST_STREAM && r_rd_cnt != LAST_IDX) begin
            w_rd_idx = r_rd_cnt + CW'(1);
        end
    end

    assign w_raddr = AW'(w_rd_idx) + (r_rd_bank ? AW'(TOTAL) : AW'(0));
    assign w_rdata = r_buf[w_raddr];

`ifdef MVM_FEEDER_DBLBUF_EN
    assign w_wr_bank_next = w_fill_done ? ~r_wr_bank : r_wr_bank;
`else
    assign w_wr_bank_next = r_wr_bank;
`endif

    // ------------------------------------------------------------------
    // Stream-side FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_rd_cnt_next   = r_rd_cnt;
        w_gap_cnt_next  = r_gap_cnt;
        w_rd_bank_next  = r_rd_bank;
        w_release       = 1'b0;
        w_mvm_data_next = '0;

        case (r_state)
            ST_LOAD: begin
                // Start as soon as the bank next in stream order is complete,
                // including the cycle its last word is being written.
                if (r_full[r_rd_bank] || (w_fill_done && (r_wr_bank == r_rd_bank))) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_rd_cnt_next   = '0;
                w_mvm_data_next = w_rdata;
                w_state_next    = ST_STREAM;
            end
            ST_STREAM: begin
                if (r_rd_cnt == LAST_IDX) begin
                    w_rd_cnt_next = '0;
                    w_state_next  = ST_WAIT_DONE;
                end else begin
                    w_rd_cnt_next   = r_rd_cnt + CW'(1);
                    w_mvm_data_next = w_rdata;
                end
            end
            ST_WAIT_DONE: begin
                if (mvm_done) begin
                    w_gap_cnt_next = '0;
                    w_state_next   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_cnt_next = '0;
                    w_release      = 1'b1;
                    w_state_next   = ST_LOAD;
`ifdef MVM_FEEDER_DBLBUF_EN
                    w_rd_bank_next = ~r_rd_bank;
`endif
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GW'(1);
                end
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bank occupancy: a bank is held from its last word until the
    // post-done gap of its own job has completed.
    // ------------------------------------------------------------------
    always_comb begin
        w_full_next = r_full;
        if (w_release) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_fill_done) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_full      <= '0;
            r_in_ready  <= 1'b1;
            r_mvm_start <= 1'b0;
            r_mvm_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rd_cnt    <= w_rd_cnt_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_wr_bank   <= w_wr_bank_next;
            r_rd_bank   <= w_rd_bank_next;
            r_full      <= w_full_next;
            r_in_ready  <= ~w_full_next[w_wr_bank_next];
            r_mvm_start <= (w_state_next == ST_START);
            r_mvm_data  <= w_mvm_data_next;
            if (w_xfer) begin
                r_wr_cnt <= w_fill_done ? '0 : r_wr_cnt + CW'(1);
            end
        end
    end

    // Buffer storage has no reset; a transfer during reset is dropped.
    always_ff @(posedge clk) begin
        if (w_xfer && !reset) begin
            r_buf[w_waddr] <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign mvm_start = r_mvm_start;
    assign mvm_data  = r_mvm_data;
    assign busy      = (r_state != ST_LOAD) || (|r_full);

endmodule

// File: tb/tb_mvm_input_feeder.sv
// ----------------------------------------------------------------------------
// tb_mvm_input_feeder
//
// Directed bench for mvm_input_feeder. The driver pushes every issued job
// word into a scoreboard queue; a monitor on the falling edge follows each
// mvm_start pulse, pops one expected word per stream cycle and compares it
// with mvm_data. Handshake and timing checks are done inline by the driver.
// Optional build: MVM_FEEDER_DBLBUF_EN (adds the ping/pong overlap test).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mvm_input_feeder;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int TOTAL = N * (N + 1);
    localparam int GAP   = N + 1;
`ifdef MVM_FEEDER_DBLBUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         mvm_start;
    logic [W-1:0] mvm_data;
    logic         mvm_done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q [$];
    int           stream_left = 0;

    logic [W-1:0] job [TOTAL];

    always #5 clk = ~clk;

    mvm_input_feeder #(
        .MAT_SCALE    (N),
        .INPUT_WIDTH  (W),
        .POST_DONE_GAP(GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mvm_start(mvm_start),
        .mvm_data (mvm_data),
        .mvm_done (mvm_done),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, msg, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset) begin
            stream_left = 0;
            exp_q.delete();
        end else if (mvm_start) begin
            check("start_while_streaming", stream_left, 0);
            stream_left = TOTAL;
        end else if (stream_left > 0) begin
            if (exp_q.size() == 0) begin
                fail_now("stream_unexpected", $sformatf("got %0h with no expected word queued", mvm_data));
            end else begin
                check("stream_word", mvm_data, exp_q.pop_front());
            end
            stream_left--;
        end else begin
            check("idle_data_zero", mvm_data, 0);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic send_word(input logic [W-1:0] d);
        bit ok;
        int budget;
        ok       = 1'b0;
        budget   = 200;
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
        while (!ok && budget > 0) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            budget--;
        end
        if (!ok) fail_now("accept_timeout", $sformatf("word %0h never accepted", d));
    endtask

    // Returns at the cycle after the last word's transfer.
    task automatic send_job(input bit toggle);
        for (int i = 0; i < TOTAL; i++) begin
            send_word(job[i]);
            if (toggle && i != TOTAL - 1) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_load_end();
        check("ready_after_last", in_ready, DBL);
        check("start_pulse", mvm_start, 1);
        tick();
        check("start_single_cycle", mvm_start, 0);
    endtask

    task automatic finish_job();
        int budget;
        budget = 200;
        while ((stream_left > 0 || exp_q.size() > 0) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) fail_now("stream_timeout", "stream did not complete");
        tick();
        tick();
        check("busy_wait_done", busy, 1);
        check("ready_wait_done", in_ready, DBL);
        mvm_done = 1'b1;
        tick();
        mvm_done = 1'b0;
        for (int k = 1; k <= GAP; k++) begin
            check("ready_after_done", in_ready, (k >= GAP) || DBL);
            if (k < GAP) tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        mvm_done = 1'b0;
        tick();
        // Transfer offered while reset is high must be discarded.
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;

        check("reset_in_ready", in_ready, 1);
        check("reset_start", mvm_start, 0);
        check("reset_data", mvm_data, 0);
        check("reset_busy", busy, 0);
        tick();

        // 1: words 1..20, valid held high
        for (int i = 0; i < TOTAL; i++) job[i] = W'(i + 1);
        send_job(1'b0);
        check_load_end();
        finish_job();

        // 2 + 3: toggled valid, spurious done during stream
        for (int i = 0; i < TOTAL; i++) job[i] = W'(8'h21 + i);
        send_job(1'b1);
        check_load_end();
        tick();
        tick();
        mvm_done = 1'b1;
        tick();
        mvm_done = 1'b0;
        check("busy_after_spurious_done", busy, 1);
        finish_job();

        // 4: signed extremes
        for (int i = 0; i < TOTAL; i++) job[i] = W'(i + 2);
        job[0]  = 8'h80;
        job[9]  = 8'h7F;
        job[19] = 8'hFF;
        send_job(1'b0);
        check_load_end();
        finish_job();

        // 5: reset while stream word 7 is on mvm_data
        for (int i = 0; i < TOTAL; i++) job[i] = W'(8'h30 + i);
        send_job(1'b0);
        check("start_pulse_t5", mvm_start, 1);
        for (int k = 0; k < 8; k++) tick();
        check("word7_before_reset", mvm_data, job[7]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_data", mvm_data, 0);
        check("abort_start", mvm_start, 0);
        check("abort_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_resume_start", mvm_start, 0);
        end
        for (int i = 0; i < TOTAL; i++) job[i] = W'(8'h50 + i);
        send_job(1'b0);
        check_load_end();
        finish_job();

`ifdef MVM_FEEDER_DBLBUF_EN
        // 6: job B loads while job A streams
        begin
            int budget;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            tick();
            for (int i = 0; i < TOTAL; i++) job[i] = W'(i + 1);
            send_job(1'b0);
            check("start_pulse_a", mvm_start, 1);
            check("ready_during_a", in_ready, 1);
            for (int i = 0; i < TOTAL; i++) job[i] = W'(101 + i);
            send_job(1'b0);
            check("ready_both_full", in_ready, 0);
            budget = 200;
            while (!(stream_left == 0 && exp_q.size() == TOTAL) && budget > 0) begin
                tick();
                budget--;
            end
            if (budget == 0) fail_now("stream_a_timeout", "job A stream did not complete");
            tick();
            check("b_waits_for_done", mvm_start, 0);
            mvm_done = 1'b1;
            tick();
            mvm_done = 1'b0;
            for (int k = 1; k <= GAP + 1; k++) begin
                check("b_start_timing", mvm_start, k == GAP + 1);
                if (k <= GAP) tick();
            end
            finish_job();
        end
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
